vga_text_line_plotter: RTL and testbench
========================================

VGA_TEXT_LINE_PLOTTER -- requirements
Module: vga_text_line_plotter

Interface
REQ-001 SHALL have parameter MAX_CHARS, default 12: capacity of the sequence input, in characters.
REQ-002 SHALL have parameter X_W, default 9: width of x coordinates.
REQ-003 SHALL have parameter Y_W, default 9: width of y coordinates.
REQ-004 SHALL have parameter COL_W, default 6: colour width.
REQ-005 SHALL have parameter PITCH, default 24: x advance per character, in pixels.
REQ-006 SHALL have parameters COL_DONE, COL_CURSOR and COL_TODO, defaults 6'h0C, 6'h3F and 6'h15: colours for typed, current and untyped characters.
REQ-007 SHALL have port clk, input, 1 bit: clock.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-009 SHALL have port start, input, 1 bit: plot request.
REQ-010 SHALL have port abort, input, 1 bit: cancel the plot in progress.
REQ-011 SHALL have port num_char, input, 8 bits: number of characters to plot.
REQ-012 SHALL have port seq, input, MAX_CHARS*8 bits: character codes, character 0 in the most significant byte.
REQ-013 SHALL have port cursor, input, 8 bits: index of the current typing position.
REQ-014 SHALL have ports x_start, input, X_W bits, and y_start, input, Y_W bits: origin of character 0.
REQ-015 SHALL have port ready, output, 1 bit: block is idle.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-017 SHALL have port chr_valid, output, 1 bit: glyph request valid.
REQ-018 SHALL have ports chr_code, output, 8 bits; chr_x, output, X_W bits; chr_y, output, Y_W bits; chr_colour, output, COL_W bits: glyph request payload.
REQ-019 SHALL have port chr_ready, input, 1 bit: glyph drawer accepts the request.
REQ-020 SHALL have port chr_done, input, 1 bit: glyph drawer finished the current glyph.

Function
REQ-021 SHALL implement states IDLE, LOAD, ISSUE, WAIT and NEXT.
REQ-022 SHALL assert ready only in IDLE.
REQ-023 SHALL, in IDLE, go to LOAD when start=1 and abort=0; start in any other state SHALL be ignored.
REQ-024 SHALL, in LOAD, capture seq, cursor, x_start and y_start, set index i=0 and set N=min(num_char, MAX_CHARS); then go to ISSUE if N>0, else pulse done and go to IDLE.
REQ-025 SHALL, in ISSUE, drive chr_valid=1 with chr_code=byte i, chr_x=x_start+i*PITCH and chr_y=y_start.
REQ-026 SHALL compute chr_x modulo 2^X_W, silently wrapping on overflow.
REQ-027 SHALL set chr_colour to COL_DONE when i<cursor, COL_CURSOR when i==cursor, else COL_TODO; cursor>=N therefore colours the whole line COL_DONE.
REQ-028 SHALL hold the chr_* payload stable while chr_valid=1 and chr_ready=0.
REQ-029 SHALL go from ISSUE to WAIT in the cycle after a clock edge with chr_valid=1 and chr_ready=1.
REQ-030 SHALL drive chr_valid=0 in every state except ISSUE.
REQ-031 SHALL sample chr_done only in WAIT; on chr_done=1, go to NEXT if i+1<N, else pulse done and go to IDLE.
REQ-032 SHALL, in NEXT, increment i by 1 and go to ISSUE.
REQ-033 SHALL give a first-request latency of 2 cycles: start sampled at edge n gives chr_valid=1 after edge n+2.
REQ-034 SHALL take ISSUE -> WAIT -> NEXT -> ISSUE, at least 3 cycles, between consecutive requests.
REQ-035 SHALL, on abort=1 in any non-IDLE state, go to IDLE at the next edge without pulsing done, drop chr_valid, and ignore the outstanding glyph's chr_done.
REQ-036 SHALL let abort take priority over chr_done and chr_ready in the same cycle.
REQ-037 SHALL not let changes on seq, cursor, x_start or y_start after LOAD affect the plot in progress.

Reset
REQ-038 SHALL apply rst_n=0 at a rising clk edge as a synchronous reset, active-low.
REQ-039 SHALL, on reset, force state IDLE and set ready=1, done=0, chr_valid=0, chr_code=0, chr_x=0, chr_y=0, chr_colour=0 and i=0.
REQ-040 SHALL, on reset mid-plot, behave as abort and additionally clear the captured registers.

Structure
REQ-041 SHALL place the state encoding, default colour constants and the default PITCH in the shared package vga_text_pkg.
REQ-042 SHALL derive the index width as $clog2(MAX_CHARS+1) locally.
REQ-043 SHALL form a natural pair with the existing glyph drawer, vga_char_drawer, connected via the chr_* handshake; the glyph drawer SHALL not be instantiated inside this block.

Verification
REQ-044 Bench SHALL cover a basic plot: N=3, seq="ABC…", x_start=10, y_start=40, cursor=1, chr_ready tied 1, chr_done 5 cycles after acceptance -> requests (0x41,10,40,COL_DONE), (0x42,34,40,COL_CURSOR), (0x43,58,40,COL_TODO); one done pulse; ready=1 afterwards.
REQ-045 Bench SHALL cover the empty and clamp cases: num_char=0 -> done after 2 cycles and no chr_valid; num_char=20 -> exactly 12 requests.
REQ-046 Bench SHALL cover backpressure: chr_ready=0 for 7 cycles -> chr_valid and payload held unchanged, then exactly one acceptance.
REQ-047 Bench SHALL cover x wrap: x_start=500, X_W=9, i=1 -> chr_x=12.
REQ-048 Bench SHALL cover abort: abort in WAIT of character 2 with simultaneous chr_done -> IDLE next cycle, no done, no further requests; a new start plots from character 0.
REQ-049 Bench SHALL cover start ignored and mid-plot reset: start pulses during a plot are ignored; rst_n=0 mid-plot -> all outputs at reset values after the edge.

Source files
------------

// File: rtl/vga_text_pkg.sv
// vga_text_pkg: state encoding and default constants shared by the text line plotter.
package vga_text_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, NEXT} state_t;
   localparam logic [5:0] COL_DONE_DEF   = 6'h0C;
   localparam logic [5:0] COL_CURSOR_DEF = 6'h3F;
   localparam logic [5:0] COL_TODO_DEF   = 6'h15;
   localparam int PITCH_DEF = 24;
endpackage

// File: rtl/vga_text_line_plotter_glyph.sv
// vga_text_line_plotter_glyph: glyph payload (code, x, colour) for character index idx.
module vga_text_line_plotter_glyph #(
   parameter int MAX_CHARS = 12,
   parameter int X_W = 9,
   parameter int COL_W = 6,
   parameter int PITCH = 24,
   parameter int IW = 4,
   parameter logic [COL_W-1:0] COL_DONE = '0,
   parameter logic [COL_W-1:0] COL_CURSOR = '0,
   parameter logic [COL_W-1:0] COL_TODO = '0
) (
   input  logic [MAX_CHARS*8-1:0] seq,
   input  logic [IW-1:0]          idx,
   input  logic [7:0]             cursor,
   input  logic [X_W-1:0]         x0,
   output logic [7:0]             code,
   output logic [X_W-1:0]         x,
   output logic [COL_W-1:0]       colour
);
   always_comb begin
      code = '0;
      for (int k = 0; k < MAX_CHARS; k++)
         if (idx == IW'(k)) code = seq[8*(MAX_CHARS-1-k) +: 8];
   end
   // x wraps modulo 2^X_W by truncation
   assign x = x0 + X_W'(int'(idx) * PITCH);
   assign colour = 8'(idx) < cursor ? COL_DONE : 8'(idx) == cursor ? COL_CURSOR : COL_TODO;
endmodule

// File: rtl/vga_text_line_plotter.sv
// vga_text_line_plotter: issues one glyph request per character of a text line
// over the chr_* handshake, colouring characters relative to the cursor.
module vga_text_line_plotter
   import vga_text_pkg::*;
#(
   parameter int MAX_CHARS = 12,
   parameter int X_W = 9,
   parameter int Y_W = 9,
   parameter int COL_W = 6,
   parameter int PITCH = PITCH_DEF,
   parameter logic [COL_W-1:0] COL_DONE = COL_W'(COL_DONE_DEF),
   parameter logic [COL_W-1:0] COL_CURSOR = COL_W'(COL_CURSOR_DEF),
   parameter logic [COL_W-1:0] COL_TODO = COL_W'(COL_TODO_DEF)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [7:0]             num_char,
   input  logic [MAX_CHARS*8-1:0] seq,
   input  logic [7:0]             cursor,
   input  logic [X_W-1:0]         x_start,
   input  logic [Y_W-1:0]         y_start,
   output logic                   ready,
   output logic                   done,
   output logic                   chr_valid,
   output logic [7:0]             chr_code,
   output logic [X_W-1:0]         chr_x,
   output logic [Y_W-1:0]         chr_y,
   output logic [COL_W-1:0]       chr_colour,
   input  logic                   chr_ready,
   input  logic                   chr_done
);
   localparam int IW = $clog2(MAX_CHARS + 1);
   localparam logic [7:0] MAX8 = 8'(MAX_CHARS);

   state_t                 state;
   logic [IW-1:0]          i, n_r;
   logic [MAX_CHARS*8-1:0] seq_r;
   logic [7:0]             cur_r;
   logic [X_W-1:0]         x_r;
   logic [Y_W-1:0]         y_r;
   logic [7:0]             g_code;
   logic [X_W-1:0]         g_x;
   logic [COL_W-1:0]       g_col;

   vga_text_line_plotter_glyph #(
      .MAX_CHARS(MAX_CHARS), .X_W(X_W), .COL_W(COL_W), .PITCH(PITCH), .IW(IW),
      .COL_DONE(COL_DONE), .COL_CURSOR(COL_CURSOR), .COL_TODO(COL_TODO)
   ) u_glyph (
      .seq(seq_r), .idx(i), .cursor(cur_r), .x0(x_r),
      .code(g_code), .x(g_x), .colour(g_col)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         ready      <= 1'b1;
         done       <= 1'b0;
         chr_valid  <= 1'b0;
         chr_code   <= '0;
         chr_x      <= '0;
         chr_y      <= '0;
         chr_colour <= '0;
         i          <= '0;
         n_r        <= '0;
         seq_r      <= '0;
         cur_r      <= '0;
         x_r        <= '0;
         y_r        <= '0;
      end else begin
         done      <= 1'b0;
         chr_valid <= 1'b0;
         // abort outranks every other condition, including chr_done/chr_ready
         if (state != IDLE && abort) begin
            state <= IDLE;
            ready <= 1'b1;
         end else begin
            case (state)
               IDLE: if (start && !abort) begin
                  state <= LOAD;
                  ready <= 1'b0;
               end
               LOAD: begin
                  seq_r <= seq;
                  cur_r <= cursor;
                  x_r   <= x_start;
                  y_r   <= y_start;
                  i     <= '0;
                  n_r   <= num_char > MAX8 ? IW'(MAX_CHARS) : IW'(num_char);
                  if (num_char == 8'd0) begin
                     done  <= 1'b1;
                     state <= IDLE;
                     ready <= 1'b1;
                  end else state <= ISSUE;
               end
               ISSUE: if (chr_valid && chr_ready) state <= WAIT;
               else begin
                  chr_valid  <= 1'b1;
                  chr_code   <= g_code;
                  chr_x      <= g_x;
                  chr_y      <= y_r;
                  chr_colour <= g_col;
               end
               WAIT: if (chr_done) begin
                  if (i + IW'(1) < n_r) state <= NEXT;
                  else begin
                     done  <= 1'b1;
                     state <= IDLE;
                     ready <= 1'b1;
                  end
               end
               NEXT: begin
                  i     <= i + IW'(1);
                  state <= ISSUE;
               end
               default: begin
                  state <= IDLE;
                  ready <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_vga_text_line_plotter.sv
// tb_vga_text_line_plotter: directed checks of the text line plotter with a
// hand-driven glyph drawer on the chr_* handshake.
module tb_vga_text_line_plotter;
   logic        clk, rst_n, start, abort, chr_ready, chr_done;
   logic [7:0]  num_char, cursor;
   logic [95:0] seq;
   logic [8:0]  x_start, y_start;
   logic        ready, done, chr_valid;
   logic [7:0]  chr_code;
   logic [8:0]  chr_x, chr_y;
   logic [5:0]  chr_colour;
   int          n_assert = 0, n_fail = 0;

   vga_text_line_plotter dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_char(num_char),
      .seq(seq), .cursor(cursor), .x_start(x_start), .y_start(y_start),
      .ready(ready), .done(done), .chr_valid(chr_valid), .chr_code(chr_code),
      .chr_x(chr_x), .chr_y(chr_y), .chr_colour(chr_colour),
      .chr_ready(chr_ready), .chr_done(chr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (!chr_valid && k < 20) begin
         tick();
         k++;
      end
      chk(tag, chr_valid, 1);
   endtask

   // one request with chr_ready=1: check payload, accept, answer chr_done 5 cycles later
   task automatic do_char(input string tag, input [7:0] code, input [8:0] x, input [8:0] y,
                          input [5:0] col, input bit last);
      wait_valid({tag, "_valid"});
      chk({tag, "_code"}, chr_code, code);
      chk({tag, "_x"}, chr_x, x);
      chk({tag, "_y"}, chr_y, y);
      chk({tag, "_col"}, chr_colour, col);
      tick();
      chk({tag, "_drop"}, chr_valid, 0);
      repeat (4) tick();
      chr_done = 1'b1;
      tick();
      chr_done = 1'b0;
      chk({tag, "_done"}, done, last);
   endtask

   initial begin
      bit ok;
      logic [7:0] s_code;
      logic [8:0] s_x, s_y;
      logic [5:0] s_col;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; chr_ready = 1'b1; chr_done = 1'b0;
      num_char = 8'd0; cursor = 8'd0; seq = "ABCDEFGHIJKL"; x_start = '0; y_start = '0;
      tick(); tick();
      chk("rst_ready", ready, 1);
      chk("rst_done", done, 0);
      chk("rst_valid", chr_valid, 0);
      chk("rst_payload", {chr_code, chr_x, chr_y, chr_colour}, 0);
      rst_n = 1'b1;

      // basic plot, with inputs changed after capture
      num_char = 8'd3; cursor = 8'd1; x_start = 9'd10; y_start = 9'd40; start = 1'b1;
      tick();
      start = 1'b0;
      chk("basic_lat1", chr_valid, 0);
      chk("basic_busy", ready, 0);
      tick();
      chk("basic_lat2", chr_valid, 0);
      seq = '0; cursor = 8'd0; x_start = 9'd200; y_start = 9'd99;
      tick();
      chk("basic_lat3", chr_valid, 1);
      do_char("b0", 8'h41, 9'd10, 9'd40, 6'h0C, 1'b0);
      do_char("b1", 8'h42, 9'd34, 9'd40, 6'h3F, 1'b0);
      do_char("b2", 8'h43, 9'd58, 9'd40, 6'h15, 1'b1);
      chk("basic_ready", ready, 1);
      tick();
      chk("basic_pulse", done, 0);

      // empty plot
      seq = "ABCDEFGHIJKL"; x_start = 9'd0; y_start = 9'd1; num_char = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("empty_done", done, 1);
      chk("empty_valid", chr_valid, 0);
      tick();
      chk("empty_pulse", done, 0);

      // clamp to 12 characters
      num_char = 8'd20; cursor = 8'd5; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 12; k++)
         do_char($sformatf("c%0d", k), 8'h41 + 8'(k), 9'(k * 24), 9'd1,
                 k < 5 ? 6'h0C : k == 5 ? 6'h3F : 6'h15, k == 11);
      ok = 1'b1;
      repeat (8) begin
         tick();
         if (chr_valid) ok = 1'b0;
      end
      chk("clamp_no13", ok, 1);

      // backpressure
      num_char = 8'd1; cursor = 8'd0; x_start = 9'd100; y_start = 9'd7; chr_ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("bp_valid");
      chk("bp_payload", {chr_code, chr_x, chr_y, chr_colour}, {8'h41, 9'd100, 9'd7, 6'h3F});
      s_code = chr_code; s_x = chr_x; s_y = chr_y; s_col = chr_colour;
      ok = 1'b1;
      repeat (7) begin
         tick();
         if (!chr_valid || chr_code !== s_code || chr_x !== s_x || chr_y !== s_y || chr_colour !== s_col)
            ok = 1'b0;
      end
      chk("bp_hold", ok, 1);
      chr_ready = 1'b1;
      tick();
      ok = 1'b1;
      repeat (5) begin
         if (chr_valid) ok = 1'b0;
         tick();
      end
      chk("bp_one_accept", ok, 1);
      chr_done = 1'b1;
      tick();
      chr_done = 1'b0;
      chk("bp_done", done, 1);

      // x wrap
      num_char = 8'd2; cursor = 8'd0; x_start = 9'd500; y_start = 9'd3; start = 1'b1;
      tick();
      start = 1'b0;
      do_char("w0", 8'h41, 9'd500, 9'd3, 6'h3F, 1'b0);
      do_char("w1", 8'h42, 9'd12, 9'd3, 6'h15, 1'b1);

      // abort in WAIT of character 2 together with chr_done
      num_char = 8'd4; cursor = 8'd0; x_start = 9'd0; y_start = 9'd0; start = 1'b1;
      tick();
      start = 1'b0;
      do_char("a0", 8'h41, 9'd0, 9'd0, 6'h3F, 1'b0);
      do_char("a1", 8'h42, 9'd24, 9'd0, 6'h15, 1'b0);
      wait_valid("a2_valid");
      tick();
      abort = 1'b1; chr_done = 1'b1;
      tick();
      abort = 1'b0; chr_done = 1'b0;
      chk("abort_ready", ready, 1);
      chk("abort_nodone", done, 0);
      ok = 1'b1;
      repeat (10) begin
         tick();
         if (chr_valid || done) ok = 1'b0;
      end
      chk("abort_quiet", ok, 1);
      num_char = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      do_char("ar0", 8'h41, 9'd0, 9'd0, 6'h3F, 1'b1);

      // start ignored mid-plot, then reset mid-plot
      num_char = 8'd3; cursor = 8'd1; x_start = 9'd10; y_start = 9'd40; start = 1'b1;
      tick();
      do_char("s0", 8'h41, 9'd10, 9'd40, 6'h0C, 1'b0);
      do_char("s1", 8'h42, 9'd34, 9'd40, 6'h3F, 1'b0);
      start = 1'b0; chr_ready = 1'b0;
      wait_valid("s2_valid");
      chk("s2_payload", {chr_code, chr_x, chr_colour}, {8'h43, 9'd58, 6'h15});
      rst_n = 1'b0;
      tick();
      chk("mrst_ready", ready, 1);
      chk("mrst_done", done, 0);
      chk("mrst_valid", chr_valid, 0);
      chk("mrst_payload", {chr_code, chr_x, chr_y, chr_colour}, 0);
      rst_n = 1'b1; chr_ready = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
